// File: rtl/cpu_pkg.sv
// Shared definitions for the ALU issue stage: FSM states, opcode fields,
// PSR bit positions and the write-enable decode used at the EXEC->WB edge.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  // op hi field, instr[15:12]
  localparam logic [3:0] OPH_RTYPE = 4'b0000;
  localparam logic [3:0] OPH_ADDI  = 4'b0101;
  localparam logic [3:0] OPH_ADDUI = 4'b0110;
  localparam logic [3:0] OPH_ADDCI = 4'b0111;
  localparam logic [3:0] OPH_SHIFT = 4'b1000;

  // op ext field, instr[7:4], for the register-register group
  localparam logic [3:0] EXT_AND  = 4'b0001;
  localparam logic [3:0] EXT_SUB  = 4'b1001;
  localparam logic [3:0] EXT_CMP  = 4'b1011;
  localparam logic [3:0] EXT_MOV  = 4'b1101;
  localparam logic [3:0] EXT_CMPU = 4'b1111;

  // op ext values that write back within the shift group
  localparam logic [3:0] SHX_0 = 4'b0000;
  localparam logic [3:0] SHX_4 = 4'b0100;
  localparam logic [3:0] SHX_8 = 4'b1000;
  localparam logic [3:0] SHX_B = 4'b1011;

  localparam int PSR_Z = 4;
  localparam int PSR_C = 3;
  localparam int PSR_F = 2;
  localparam int PSR_N = 1;
  localparam int PSR_L = 0;

  typedef struct packed {
    logic reg_we;
    logic psr_we;
  } wr_ctl_t;

  // Anything not listed is a NOP/WAIT and touches neither regs nor PSR.
  function automatic wr_ctl_t decode_wr(input logic [3:0] hi, input logic [3:0] ext);
    wr_ctl_t c;
    c = '0;
    case (hi)
      OPH_RTYPE: begin
        if (ext >= EXT_AND && ext <= EXT_SUB) begin
          c.reg_we = 1'b1;
          c.psr_we = 1'b1;
        end else if (ext == EXT_MOV) begin
          c.reg_we = 1'b1;
        end else if (ext == EXT_CMP || ext == EXT_CMPU) begin
          c.psr_we = 1'b1;
        end
      end
      OPH_ADDI, OPH_ADDUI, OPH_ADDCI: begin
        c.reg_we = 1'b1;
        c.psr_we = 1'b1;
      end
      OPH_SHIFT: begin
        if (ext == SHX_0 || ext == SHX_4 || (ext >= SHX_8 && ext <= SHX_B)) begin
          c.reg_we = 1'b1;
          c.psr_we = 1'b1;
        end
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_reg_file.sv
// 16 x 16 register file: two combinational operand ports, a debug port,
// one synchronous write port and a synchronous active-low clear.
module reg_file #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [3:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [3:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a  = regs_q[raddr_a];
  assign rdata_b  = regs_q[raddr_b];
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback stage for the external combinational ALU: IDLE accepts an
// instruction, EXEC lets the ALU settle and captures its outputs, WB commits.
module alu_issue_ctrl
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [15:0]       alu_opcode,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_c,
  input  logic [4:0]        alu_flags,
  output logic [4:0]        psr,
  output logic              wb_valid,
  output logic [3:0]        wb_reg,
  output logic [DATA_W-1:0] wb_data,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_t            state_q;
  logic [15:0]       ir_q;
  logic [DATA_W-1:0] res_q;
  logic [4:0]        flg_q;
  logic [4:0]        psr_q;
  logic              reg_we_q;
  logic              psr_we_q;
  logic              ready_q;
  logic              wb_valid_q;
  wr_ctl_t           dec_d;
  logic              rf_we_d;

  assign dec_d   = decode_wr(ir_q[15:12], ir_q[7:4]);
  assign rf_we_d = (state_q == WB) && reg_we_q;

  reg_file #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS)
  ) u_reg_file (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we_d),
    .waddr   (ir_q[11:8]),
    .wdata   (res_q),
    .raddr_a (ir_q[11:8]),
    .rdata_a (alu_a),
    .raddr_b (ir_q[3:0]),
    .rdata_b (alu_b),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ir_q       <= '0;
      res_q      <= '0;
      flg_q      <= '0;
      psr_q      <= '0;
      reg_we_q   <= 1'b0;
      psr_we_q   <= 1'b0;
      ready_q    <= 1'b1;
      wb_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (instr_valid && ready_q) begin
            ir_q    <= instr;
            ready_q <= 1'b0;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          res_q      <= alu_c;
          flg_q      <= alu_flags;
          reg_we_q   <= dec_d.reg_we;
          psr_we_q   <= dec_d.psr_we;
          wb_valid_q <= dec_d.reg_we;
          state_q    <= WB;
        end
        WB: begin
          // Register write happens in reg_file on this same edge.
          if (psr_we_q) psr_q <= flg_q;
          wb_valid_q <= 1'b0;
          ready_q    <= 1'b1;
          state_q    <= IDLE;
        end
        default: begin
          wb_valid_q <= 1'b0;
          ready_q    <= 1'b1;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign instr_ready = ready_q;
  assign alu_opcode  = ir_q;
  assign alu_cin     = psr_q[PSR_C];
  assign psr         = psr_q;
  assign wb_valid    = wb_valid_q;
  assign wb_reg      = ir_q[11:8];
  assign wb_data     = res_q;

endmodule
